// File: rtl/iomem_gpio_pkg.sv
// Shared definitions for the iomem GPIO peripheral: register word
// offsets, synchroniser depth, bus FSM states and a strobe helper.
package iomem_gpio_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic [5:0] OFS_OUT     = 6'h00;
    localparam logic [5:0] OFS_DIR     = 6'h01;
    localparam logic [5:0] OFS_IN      = 6'h02;
    localparam logic [5:0] OFS_SET     = 6'h03;
    localparam logic [5:0] OFS_CLR     = 6'h04;
    localparam logic [5:0] OFS_TGL     = 6'h05;
    localparam logic [5:0] OFS_RISE_EN = 6'h06;
    localparam logic [5:0] OFS_FALL_EN = 6'h07;
    localparam logic [5:0] OFS_STATUS  = 6'h08;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } bus_state_e;

    // Expand 4 byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin synchroniser with one extra history flop for edge detection.
// Ports: i_clk, i_reset, i_in (async pads), o_in_sync, o_rise, o_fall.
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_in_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);
    import iomem_gpio_pkg::*;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_in_sync = r_sync[SYNC_STAGES-1];
    assign o_rise    = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall    = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: OUT/DIR/IN, atomic
// set/clear/toggle, per-pin rise/fall interrupt status and level irq.
// Ports: i_clk, i_reset, iomem bus (i_iomem_valid, o_iomem_ready,
// i_iomem_wstrb, i_iomem_addr, i_iomem_wdata, o_iomem_rdata),
// pads (i_gpio_in, o_gpio_out, o_gpio_oe) and o_irq.
module iomem_gpio #(
    parameter int               WIDTH     = 8,
    parameter logic [7:0]       BASE_ADDR = 8'h03,
    parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_iomem_valid,
    output logic             o_iomem_ready,
    input  logic [3:0]       i_iomem_wstrb,
    input  logic [31:0]      i_iomem_addr,
    input  logic [31:0]      i_iomem_wdata,
    output logic [31:0]      o_iomem_rdata,
    input  logic [WIDTH-1:0] i_gpio_in,
    output logic [WIDTH-1:0] o_gpio_out,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);
    import iomem_gpio_pkg::*;

    bus_state_e       r_state;
    bus_state_e       w_state_nxt;
    logic [31:0]      r_rdata;
    logic             r_irq;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;

    logic             w_sel;
    logic             w_req;
    logic             w_wr;
    logic [5:0]       w_ofs;
    logic [31:0]      w_mask32;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] w_in_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_w1c;
    logic             w_unused;

    gpio_sync_edge #(
        .WIDTH(WIDTH)
    ) u_sync (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_in     (i_gpio_in),
        .o_in_sync(w_in_sync),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    // Bits [23:8] alias the map across the region.
    assign w_sel    = (i_iomem_addr[31:24] == BASE_ADDR);
    assign w_ofs    = i_iomem_addr[7:2];
    assign w_mask32 = strb_mask(i_iomem_wstrb);
    assign w_mask   = w_mask32[WIDTH-1:0];
    // Unstrobed bytes contribute zero, which also suits SET/CLR/TGL.
    assign w_wd     = i_iomem_wdata[WIDTH-1:0] & w_mask;
    assign w_wr     = w_req && (i_iomem_wstrb != 4'b0000);

    assign w_unused = &{1'b0, i_iomem_addr[23:8], i_iomem_addr[1:0],
                        i_iomem_wdata, w_mask32};

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_iomem_valid && w_sel) begin
                    w_req       = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd = '0;
        case (w_ofs)
            OFS_OUT:     w_rd = r_out;
            OFS_DIR:     w_rd = r_dir;
            OFS_IN:      w_rd = w_in_sync;
            OFS_RISE_EN: w_rd = r_rise_en;
            OFS_FALL_EN: w_rd = r_fall_en;
            OFS_STATUS:  w_rd = r_status;
            default:     w_rd = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req) begin
                r_rdata <= 32'(w_rd);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out     <= RESET_OUT;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (w_ofs)
                OFS_OUT:     r_out     <= (r_out & ~w_mask) | w_wd;
                OFS_DIR:     r_dir     <= (r_dir & ~w_mask) | w_wd;
                OFS_SET:     r_out     <= r_out | w_wd;
                OFS_CLR:     r_out     <= r_out & ~w_wd;
                OFS_TGL:     r_out     <= r_out ^ w_wd;
                OFS_RISE_EN: r_rise_en <= (r_rise_en & ~w_mask) | w_wd;
                OFS_FALL_EN: r_fall_en <= (r_fall_en & ~w_mask) | w_wd;
                default:     ;
            endcase
        end
    end

    assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_w1c   = (w_wr && (w_ofs == OFS_STATUS)) ? w_wd : '0;

    // A new event wins over a simultaneous W1C of the same bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_w1c) | w_event;
            r_irq    <= |r_status;
        end
    end

    assign o_iomem_ready = (r_state == ST_ACK);
    assign o_iomem_rdata = r_rdata;
    assign o_gpio_out    = r_out;
    assign o_gpio_oe     = r_dir;
    assign o_irq         = r_irq;

endmodule
